// File: rtl/demux1to4_seq.sv
// rtl/demux1to4_seq.sv - sequential 1-to-4 lane demux that assembles frames with a one-deep output holding register
module demux1to4_seq #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                in_valid,
  input  logic                mode,
  input  logic [1:0]          select,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] data_out,
  output logic                out_valid,
  output logic [1:0]          chan,
  output logic                overrun
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_t;

  out_state_t          r_state;
  out_state_t          w_state_nxt;
  logic                r_mode;
  logic [3:0]          r_mask;
  logic [4*DATA_W-1:0] r_buf;
  logic [1:0]          r_chan;
  logic [4*DATA_W-1:0] r_dout;
  logic                r_overrun;

  logic                w_mode_chg;
  logic                w_wr;
  logic [1:0]          w_lane;
  logic [3:0]          w_lane_bit;
  logic [3:0]          w_mask_set;
  logic                w_complete;
  logic [4*DATA_W-1:0] w_buf_nxt;
  logic                w_load;
  logic                w_drop;

  // A mode flip throws away the partial frame, so the write in that cycle is not taken.
  assign w_mode_chg = (mode != r_mode);
  assign w_wr       = in_valid && !w_mode_chg;
  assign w_lane     = mode ? select : r_chan;
  assign w_complete = w_wr && (w_mask_set == 4'b1111);

  // Next assembly contents and mask as if the current write lands, including the completing lane.
  always_comb begin
    w_lane_bit = 4'b0001 << w_lane;
    w_mask_set = r_mask | w_lane_bit;
    w_buf_nxt  = r_buf;
    w_buf_nxt[w_lane*DATA_W +: DATA_W] = data_in;
  end

  // Output state register: EMPTY holds nothing, FULL holds an unconsumed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output next-state: load on completion when there is room, drop when the consumer is stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_complete) begin
          if (out_ready) begin
            w_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Assembly buffer, lane pointer, holding register and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_mask    <= 4'b0000;
      r_buf     <= '0;
      r_chan    <= 2'd0;
      r_dout    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_mode <= mode;
      if (w_mode_chg) begin
        r_mask <= 4'b0000;
        r_chan <= 2'd0;
      end else if (in_valid) begin
        r_buf  <= w_buf_nxt;
        r_mask <= w_complete ? 4'b0000 : w_mask_set;
        r_chan <= mode ? select : (r_chan + 2'd1);
      end
      if (w_load) begin
        r_dout <= w_buf_nxt;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign data_out  = r_dout;
  assign out_valid = (r_state == S_FULL);
  assign chan      = r_chan;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_demux1to4_seq.sv
// tb/tb_demux1to4_seq.sv - self-checking bench for demux1to4_seq with a frame scoreboard
module tb_demux1to4_seq;

  localparam int DATA_W = 1;

  logic                clk;
  logic                rst_n;
  logic [DATA_W-1:0]   data_in;
  logic                in_valid;
  logic                mode;
  logic [1:0]          select;
  logic                out_ready;
  logic [4*DATA_W-1:0] data_out;
  logic                out_valid;
  logic [1:0]          chan;
  logic                overrun;

  int n_tests;
  int n_fail;
  logic [4*DATA_W-1:0] sb_q[$];

  demux1to4_seq #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .mode      (mode),
    .select    (select),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .chan      (chan),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one write, applied on the next rising edge.
  task automatic wr(input logic d, input logic [1:0] sel);
    data_in  = d;
    select   = sel;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  // Frame monitor: every accepted handshake consumes one expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_frame", {28'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_frame", {28'd0, data_out}, {28'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    data_in   = '0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    select    = 2'd0;
    out_ready = 1'b1;

    // Power-on: inputs toggling under reset must be ignored.
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      data_in  = 1'b1;
      cyc();
      chk("por_dout", {28'd0, data_out}, 32'd0);
      chk("por_valid", {31'd0, out_valid}, 32'd0);
      chk("por_chan", {30'd0, chan}, 32'd0);
      chk("por_ovr", {31'd0, overrun}, 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Auto mode: 0,1,0,1 into lanes 0..3.
    for (int i = 0; i < 4; i++) begin
      chk("auto_chan", {30'd0, chan}, i);
      if (i == 3) sb_q.push_back(4'b1010);
      wr(logic'(i % 2), 2'd0);
    end
    chk("auto_valid", {31'd0, out_valid}, 32'd1);
    chk("auto_dout", {28'd0, data_out}, 32'hA);
    chk("auto_chan_wrap", {30'd0, chan}, 32'd0);
    cyc();
    chk("auto_valid_1cyc", {31'd0, out_valid}, 32'd0);

    // Explicit mode: absorb the mode flip, then lanes 3,2,1,0.
    mode = 1'b1;
    cyc();
    wr(1'b1, 2'd3);
    chk("expl_chan", {30'd0, chan}, 32'd3);
    wr(1'b0, 2'd2);
    wr(1'b1, 2'd1);
    sb_q.push_back(4'b1010);
    wr(1'b0, 2'd0);
    chk("expl_valid", {31'd0, out_valid}, 32'd1);
    chk("expl_dout", {28'd0, data_out}, 32'hA);
    chk("expl_chan_ld", {30'd0, chan}, 32'd0);
    cyc();

    // Explicit variant: lane 0 rewritten, frame only after all four lanes.
    wr(1'b1, 2'd0);
    wr(1'b0, 2'd0);
    wr(1'b1, 2'd1);
    wr(1'b0, 2'd2);
    chk("rewr_no_early", {31'd0, out_valid}, 32'd0);
    sb_q.push_back(4'b1010);
    wr(1'b1, 2'd3);
    chk("rewr_valid", {31'd0, out_valid}, 32'd1);
    chk("rewr_dout", {28'd0, data_out}, 32'hA);
    cyc();

    // Backpressure: second frame dropped while the first is held.
    mode      = 1'b0;
    out_ready = 1'b0;
    cyc();
    sb_q.push_back(4'b1010);
    for (int i = 0; i < 4; i++) wr(logic'(i % 2), 2'd0);
    chk("bp_ovr_pre", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, 2'd0);
      chk("bp_hold", {28'd0, data_out}, 32'hA);
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_ovr", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);
    chk("bp_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Mode switch mid-frame: the flip-cycle write is ignored and chan returns to 0.
    wr(1'b1, 2'd0);
    wr(1'b1, 2'd0);
    mode = 1'b1;
    wr(1'b0, 2'd2);
    chk("msw_chan", {30'd0, chan}, 32'd0);
    wr(1'b0, 2'd0);
    wr(1'b1, 2'd1);
    wr(1'b0, 2'd2);
    chk("msw_no_early", {31'd0, out_valid}, 32'd0);
    sb_q.push_back(4'b1010);
    wr(1'b1, 2'd3);
    chk("msw_valid", {31'd0, out_valid}, 32'd1);
    chk("msw_dout", {28'd0, data_out}, 32'hA);

    // Reset mid-frame between edges: outputs clear at once.
    mode = 1'b0;
    cyc();
    wr(1'b1, 2'd0);
    wr(1'b1, 2'd0);
    wr(1'b1, 2'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_chan", {30'd0, chan}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_dout", {28'd0, data_out}, 32'd0);
    chk("arst_ovr", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(1'b1, 2'd0);
    wr(1'b0, 2'd0);
    wr(1'b0, 2'd0);
    chk("arst_no_early", {31'd0, out_valid}, 32'd0);
    sb_q.push_back(4'b0001);
    wr(1'b0, 2'd0);
    chk("arst_valid_after", {31'd0, out_valid}, 32'd1);
    chk("arst_dout_after", {28'd0, data_out}, 32'h1);

    repeat (3) cyc();
    chk("sb_left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to4_seq.md
DEMUX1TO4_SEQ -- requirements
Module: demux1to4_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 1, giving the width of each of the four lanes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port data_in, input, DATA_W, the lane payload.
REQ-005 SHALL have port in_valid, input, 1, meaning data_in is presented this cycle.
REQ-006 SHALL have port mode, input, 1: 0 selects auto round-robin mode; 1 selects explicit-select mode.
REQ-007 SHALL have port select, input, 2, the target lane in explicit mode; it is ignored in auto mode.
REQ-008 SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-009 SHALL have port data_out, output, 4*DATA_W, the assembled frame; lane i occupies data_out[i*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid, output, 1, meaning data_out holds an unconsumed frame.
REQ-011 SHALL have port chan, output, 2, the lane pointer.
REQ-012 SHALL have port overrun, output, 1, a sticky frame-drop flag.

Function
REQ-013 SHALL keep an assembly buffer of 4 lanes and a 4-bit written mask; data_out is a separate holding register.
REQ-014 In auto mode, each cycle with in_valid=1 SHALL write data_in into lane chan and set mask[chan].
- In the same cycle, chan increments modulo 4 (3 wraps to 0).
REQ-015 In explicit mode, each cycle with in_valid=1 SHALL write data_in into lane select and set mask[select].
- In the same cycle, chan is loaded with select.
- Rewriting an already-written lane overwrites its data; the mask is unchanged.
REQ-016 A frame SHALL complete on the edge where the mask becomes 4'b1111.
- On that edge, the assembled lanes (including the lane written that cycle) transfer to data_out.
- On that edge, the mask clears to 0.
- Latency: out_valid is visible the cycle after the completing write.
REQ-017 The output side SHALL be a two-state machine.
- EMPTY (out_valid=0): a completion moves it to FULL.
- FULL (out_valid=1): out_ready=1 without a completion returns it to EMPTY.
- FULL with out_ready=1 and a completion in the same cycle: the new frame loads and the state stays FULL.
- FULL with out_ready=0 and a completion: the new frame is dropped, data_out holds, and overrun sets to 1; the mask still clears.
REQ-018 data_out SHALL be stable whenever out_valid=1 and out_ready=0.
REQ-019 overrun SHALL stay 1 until reset.
REQ-020 The block SHALL register mode each cycle; when mode differs from its registered value:
- the partial frame is discarded: mask cleared, chan set to 0;
- any in_valid that same cycle is ignored;
- out_valid and data_out are unaffected.
REQ-021 A cycle with in_valid=0 SHALL leave the mask, chan and lane contents unchanged.

Reset
REQ-022 On rst_n=0, the block SHALL immediately, without waiting for clk, clear all of the following:
- data_out, out_valid, chan, overrun to 0;
- the mask and assembly buffer to 0;
- the registered mode to 0.
REQ-023 While rst_n=0, all inputs SHALL be ignored.
REQ-024 The first write SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-025 Power-on: hold rst_n=0 with in_valid=1 toggling -> data_out=0, out_valid=0, chan=0, overrun=0 throughout.
REQ-026 Auto mode, DATA_W=1, out_ready=1, data_in 0,1,0,1 on four consecutive cycles:
- chan reads 0,1,2,3 across those cycles;
- the cycle after the fourth write shows data_out=4'b1010, out_valid=1 for exactly one cycle.
REQ-027 Explicit mode, select 11,10,01,00 with data 1,0,1,0 -> data_out=4'b1010, out_valid=1.
- Variant: repeat with select 00 written twice (1 then 0) before lanes 01,10,11 -> lane 0 = 0; completion only after all four lanes are written.
REQ-028 Backpressure: out_ready=0; auto frame 0,1,0,1 followed by frame 1,1,1,1 -> out_valid=1, data_out stays 4'b1010, overrun=1.
- Then out_ready=1 for one cycle -> out_valid=0; overrun stays 1.
REQ-029 Mode switch mid-frame: two auto writes, then mode=1 with in_valid=1 -> that write is ignored, chan=0.
- No out_valid until four further explicit lane writes.
REQ-030 Reset mid-frame: drop rst_n between clock edges after three auto writes -> outputs clear immediately.
- After release, four writes are needed for a frame.
